// File: rtl/sync_clock_divider_pkg.sv
// Shared types and constants for the synced clock divider slice.
// State encoding, default counter width and minimum divisor live here.
package sync_clk_pkg;

    localparam int unsigned DEF_CNT_W = 16;
    localparam int unsigned MIN_DIV   = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

endpackage : sync_clk_pkg

// File: rtl/sync_clock_divider_if.sv
// Control and status bundle between the divider and its consumers.
// master drives ENABLE/DIV/SYNC_IN and observes the divided outputs.
interface sync_clock_divider_if #(
    parameter int unsigned CNT_W = sync_clk_pkg::DEF_CNT_W
);

    logic             ENABLE;
    logic [CNT_W-1:0] DIV;
    logic             SYNC_IN;
    logic             CLK_OUT;
    logic             TICK;
    logic             LOCKED;
    logic             SYNC_ERR;

    modport master (
        output ENABLE,
        output DIV,
        output SYNC_IN,
        input  CLK_OUT,
        input  TICK,
        input  LOCKED,
        input  SYNC_ERR
    );

    modport slave (
        input  ENABLE,
        input  DIV,
        input  SYNC_IN,
        output CLK_OUT,
        output TICK,
        output LOCKED,
        output SYNC_ERR
    );

endinterface : sync_clock_divider_if

// File: rtl/sync_clock_divider_edge.sv
// Multi-flop synchronizer for the external sync input followed by a
// registered rising-edge detector; EDGE is a single-cycle pulse.
module sync_edge_detect #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic CLK,
    input  logic RESET,
    input  logic D_ASYNC,
    output logic EDGE
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   last_q;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            sync_q <= '0;
            last_q <= 1'b0;
            EDGE   <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], D_ASYNC};
            last_q <= sync_q[SYNC_STAGES-1];
            EDGE   <= sync_q[SYNC_STAGES-1] & ~last_q;
        end
    end

endmodule : sync_edge_detect

// File: rtl/sync_clock_divider.sv
// Phase-alignable clock divider: divided clock, period-start strobe,
// lock tracking against an external sync and phase-error reporting.
module sync_clock_divider
    import sync_clk_pkg::*;
#(
    parameter int unsigned CNT_W       = DEF_CNT_W,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned PHASE_TOL   = 1,
    parameter int unsigned MISS_LIMIT  = 4
) (
    input  logic               CLK,
    input  logic               RESET,
    sync_clock_divider_if.slave bus
);

    localparam int unsigned   MISS_W = $clog2(MISS_LIMIT + 1);
    localparam logic [CNT_W:0] TOL   = (CNT_W + 1)'(PHASE_TOL);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  div_l;
    logic [MISS_W-1:0] miss;
    logic              acq_seen;
    logic              sync_edge;

    logic [CNT_W-1:0]  div_in;
    logic [CNT_W-1:0]  cnt_next;
    logic              wrap;
    logic              restart;
    logic              in_tol;

    sync_edge_detect #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .CLK    (CLK),
        .RESET  (RESET),
        .D_ASYNC(bus.SYNC_IN),
        .EDGE   (sync_edge)
    );

    // Tolerance is evaluated one bit wider so small divisors cannot underflow.
    always_comb begin
        div_in   = (bus.DIV < CNT_W'(MIN_DIV)) ? CNT_W'(MIN_DIV) : bus.DIV;
        wrap     = (cnt == div_l - CNT_W'(1));
        restart  = sync_edge | wrap;
        cnt_next = restart ? '0 : cnt + CNT_W'(1);
        in_tol   = (({1'b0, cnt} + TOL) >= ({1'b0, div_l} - (CNT_W + 1)'(1)))
                 || ({1'b0, cnt} <= TOL);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state        <= IDLE;
            cnt          <= '0;
            div_l        <= CNT_W'(MIN_DIV);
            miss         <= '0;
            acq_seen     <= 1'b0;
            bus.CLK_OUT  <= 1'b0;
            bus.TICK     <= 1'b0;
            bus.LOCKED   <= 1'b0;
            bus.SYNC_ERR <= 1'b0;
        end else if (!bus.ENABLE) begin
            state        <= IDLE;
            cnt          <= '0;
            miss         <= '0;
            acq_seen     <= 1'b0;
            bus.CLK_OUT  <= 1'b0;
            bus.TICK     <= 1'b0;
            bus.LOCKED   <= 1'b0;
            bus.SYNC_ERR <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // Leaving IDLE starts a fresh period at cnt=0 (high phase).
                    state        <= ACQUIRE;
                    cnt          <= '0;
                    div_l        <= div_in;
                    miss         <= '0;
                    acq_seen     <= 1'b0;
                    bus.CLK_OUT  <= 1'b1;
                    bus.TICK     <= 1'b1;
                    bus.LOCKED   <= 1'b0;
                    bus.SYNC_ERR <= 1'b0;
                end

                ACQUIRE, LOCKED: begin
                    cnt          <= cnt_next;
                    bus.TICK     <= restart;
                    bus.CLK_OUT  <= (cnt_next < (div_l >> 1));
                    bus.SYNC_ERR <= 1'b0;
                    if (restart) begin
                        div_l <= div_in;
                    end

                    if (state == ACQUIRE) begin
                        if (sync_edge) begin
                            acq_seen <= 1'b1;
                            if (acq_seen && in_tol) begin
                                state      <= LOCKED;
                                bus.LOCKED <= 1'b1;
                                miss       <= '0;
                            end
                        end
                    end else if (sync_edge) begin
                        if (in_tol) begin
                            miss <= '0;
                        end else begin
                            state        <= ACQUIRE;
                            bus.LOCKED   <= 1'b0;
                            bus.SYNC_ERR <= 1'b1;
                            acq_seen     <= 1'b1;
                            miss         <= '0;
                        end
                    end else if (wrap) begin
                        // Any sync restarts the period, so a bare wrap means none arrived.
                        if (miss + MISS_W'(1) == MISS_W'(MISS_LIMIT)) begin
                            state      <= ACQUIRE;
                            bus.LOCKED <= 1'b0;
                            acq_seen   <= 1'b0;
                            miss       <= '0;
                        end else begin
                            miss <= miss + MISS_W'(1);
                        end
                    end
                end

                default: begin
                    state        <= IDLE;
                    cnt          <= '0;
                    bus.CLK_OUT  <= 1'b0;
                    bus.TICK     <= 1'b0;
                    bus.LOCKED   <= 1'b0;
                    bus.SYNC_ERR <= 1'b0;
                end
            endcase
        end
    end

endmodule : sync_clock_divider

// File: tb/tb_sync_clock_divider.sv
// Directed bench for sync_clock_divider: free-run patterns, acquire/lock,
// phase error, miss limit, divisor boundaries and mid-operation reset.
module tb_sync_clock_divider;

    logic CLK;
    logic RESET;
    int   n_total;
    int   n_bad;
    int   cyc;

    sync_clock_divider_if #(.CNT_W(16)) bus ();

    sync_clock_divider #(
        .CNT_W      (16),
        .SYNC_STAGES(2),
        .PHASE_TOL  (1),
        .MISS_LIMIT (4)
    ) dut (
        .CLK  (CLK),
        .RESET(RESET),
        .bus  (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int c);
        while (cyc < c) step();
    endtask

    // SYNC_IN high for one cycle, first sampled at edge c+1.
    task automatic pulse_at(input int c);
        run_to(c);
        bus.SYNC_IN = 1'b1;
        step();
        bus.SYNC_IN = 1'b0;
    endtask

    task automatic restart(input logic [15:0] d);
        RESET       = 1'b1;
        bus.ENABLE  = 1'b1;
        bus.DIV     = d;
        bus.SYNC_IN = 1'b0;
        repeat (3) step();
        check_val("rst_clk_out", bus.CLK_OUT, 0);
        check_val("rst_tick", bus.TICK, 0);
        check_val("rst_locked", bus.LOCKED, 0);
        check_val("rst_sync_err", bus.SYNC_ERR, 0);
        RESET = 1'b0;
        cyc   = 0;
    endtask

    task automatic run_pattern(input string tag, input logic [15:0] tk, input logic [15:0] ck,
                               input int chg_cyc, input logic [15:0] new_div);
        for (int i = 1; i <= 16; i++) begin
            step();
            check_val({tag, "_tick"}, bus.TICK, tk[16-i]);
            check_val({tag, "_clk"}, bus.CLK_OUT, ck[16-i]);
            check_val({tag, "_locked"}, bus.LOCKED, 0);
            if (cyc == chg_cyc) bus.DIV = new_div;
        end
    endtask

    // Syncs sampled at E3 (realign at E6, cnt was 4) and E11 (coincides with wrap at E14).
    task automatic lock_up();
        pulse_at(2);
        run_to(6);
        check_val("acq_realign_tick", bus.TICK, 1);
        check_val("acq_realign_locked", bus.LOCKED, 0);
        check_val("acq_realign_err", bus.SYNC_ERR, 0);
        pulse_at(10);
        run_to(13);
        check_val("acq_prelock", bus.LOCKED, 0);
        run_to(14);
        check_val("lock_tick", bus.TICK, 1);
        check_val("lock_locked", bus.LOCKED, 1);
        check_val("lock_err", bus.SYNC_ERR, 0);
        run_to(15);
        check_val("lock_single_tick", bus.TICK, 0);
    endtask

    initial begin
        n_total     = 0;
        n_bad       = 0;
        cyc         = 0;
        RESET       = 1'b1;
        bus.ENABLE  = 1'b0;
        bus.DIV     = 16'd8;
        bus.SYNC_IN = 1'b0;

        // Free run, DIV=8: high 4, low 4, TICK every 8.
        restart(16'd8);
        run_pattern("div8", 16'b1000_0000_1000_0000, 16'b1111_0000_1111_0000, 0, 16'd0);

        // ENABLE low returns everything to idle.
        bus.ENABLE = 1'b0;
        step();
        step();
        check_val("dis_clk_out", bus.CLK_OUT, 0);
        check_val("dis_tick", bus.TICK, 0);
        check_val("dis_locked", bus.LOCKED, 0);

        // DIV=0 and DIV=1 clamp to period 2.
        restart(16'd0);
        run_pattern("div0", 16'b1010_1010_1010_1010, 16'b1010_1010_1010_1010, 0, 16'd0);
        restart(16'd1);
        run_pattern("div1", 16'b1010_1010_1010_1010, 16'b1010_1010_1010_1010, 0, 16'd0);

        // DIV=7: high 3, low 4.
        restart(16'd7);
        run_pattern("div7", 16'b1000_0001_0000_0010, 16'b1110_0001_1100_0011, 0, 16'd0);

        // DIV 8->5 at cyc3: current period stays 8, next is 5.
        restart(16'd8);
        run_pattern("div8to5", 16'b1000_0000_1000_0100, 16'b1111_0000_1100_0110, 3, 16'd5);

        // Acquire/lock, in-tolerance early sync, then out-of-tolerance sync.
        restart(16'd8);
        lock_up();
        pulse_at(17);
        run_to(20);
        check_val("early_pre_tick", bus.TICK, 0);
        run_to(21);
        check_val("early_tick", bus.TICK, 1);
        check_val("early_locked", bus.LOCKED, 1);
        check_val("early_err", bus.SYNC_ERR, 0);
        pulse_at(22);
        run_to(25);
        check_val("perr_pre_err", bus.SYNC_ERR, 0);
        check_val("perr_pre_locked", bus.LOCKED, 1);
        run_to(26);
        check_val("perr_err", bus.SYNC_ERR, 1);
        check_val("perr_locked", bus.LOCKED, 0);
        check_val("perr_tick", bus.TICK, 1);
        run_to(27);
        check_val("perr_err_clr", bus.SYNC_ERR, 0);
        check_val("perr_tick_clr", bus.TICK, 0);

        // Miss limit: syncs stop after lock at E14; lock drops at 4th bare wrap (E46).
        restart(16'd8);
        lock_up();
        run_to(22);
        check_val("miss1_tick", bus.TICK, 1);
        run_to(30);
        check_val("miss2_tick", bus.TICK, 1);
        check_val("miss2_locked", bus.LOCKED, 1);
        run_to(38);
        check_val("miss3_tick", bus.TICK, 1);
        run_to(45);
        check_val("miss4_pre_locked", bus.LOCKED, 1);
        run_to(46);
        check_val("miss4_tick", bus.TICK, 1);
        check_val("miss4_locked", bus.LOCKED, 0);
        check_val("miss4_err", bus.SYNC_ERR, 0);
        run_to(54);
        check_val("miss5_tick", bus.TICK, 1);

        // Held-high sync gives a single realign.
        restart(16'd8);
        run_to(2);
        bus.SYNC_IN = 1'b1;
        run_to(6);
        check_val("hold_realign_tick", bus.TICK, 1);
        run_to(13);
        check_val("hold_mid_tick", bus.TICK, 0);
        run_to(14);
        check_val("hold_wrap_tick", bus.TICK, 1);
        check_val("hold_locked", bus.LOCKED, 0);
        bus.SYNC_IN = 1'b0;

        // Reset while locked at cnt=5, then a full re-acquire is needed.
        restart(16'd8);
        lock_up();
        run_to(19);
        RESET = 1'b1;
        step();
        check_val("mrst_clk_out", bus.CLK_OUT, 0);
        check_val("mrst_tick", bus.TICK, 0);
        check_val("mrst_locked", bus.LOCKED, 0);
        check_val("mrst_err", bus.SYNC_ERR, 0);
        RESET = 1'b0;
        step();
        check_val("mrst_start_tick", bus.TICK, 1);
        pulse_at(24);
        run_to(28);
        check_val("mrst_realign_tick", bus.TICK, 1);
        check_val("mrst_realign_locked", bus.LOCKED, 0);
        pulse_at(32);
        run_to(36);
        check_val("mrst_relock", bus.LOCKED, 1);
        check_val("mrst_relock_tick", bus.TICK, 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_sync_clock_divider

// File: doc/sync_clock_divider.md
Name: sync_clock_divider

Overview:
- Generates a phase-aligned divided clock (CLK_OUT) and a one-cycle TICK strobe from the system clock.
- Downstream D/Q register stages consume these outputs as their D/enable inputs.
- An external sync pulse re-aligns the divider phase; lock state and phase errors are reported.
- Sits directly upstream of the synced-clock register stages in the top level.

Parameters:
CNT_W, 16, width of divisor and phase counter
SYNC_STAGES, 2, synchronizer flops on SYNC_IN (minimum 2)
PHASE_TOL, 1, allowed sync offset in CLK cycles from the expected wrap point
MISS_LIMIT, 4, consecutive periods without sync before lock is dropped

Ports:
CLK  in  1  system clock, all logic on rising edge
RESET  in  1  synchronous, active-high reset
ENABLE  in  1  run divider; 0 forces IDLE
DIV  in  CNT_W  divisor in CLK cycles; values <2 are treated as 2
SYNC_IN  in  1  asynchronous external sync, rising-edge significant
CLK_OUT  out  1  divided clock, registered
TICK  out  1  one-cycle strobe at each period start
LOCKED  out  1  high while in LOCKED state
SYNC_ERR  out  1  one-cycle pulse on an out-of-tolerance sync while LOCKED

Behaviour:
- Interface: one clock (CLK); reset (RESET) is synchronous and active-high.
- Reset values:
  - cnt=0, div_l=2, miss=0, synchronizer flops=0, state=IDLE.
  - CLK_OUT=0, TICK=0, LOCKED=0, SYNC_ERR=0.
  - RESET mid-period discards phase and lock immediately.
- Sync path:
  - SYNC_IN passes through SYNC_STAGES flops, then a rising-edge detect gives sync_edge.
  - A SYNC_IN high first sampled at edge k produces cnt=0 and TICK=1 after edge k+SYNC_STAGES+1.
  - Held-high SYNC_IN yields one edge only.
- div_l latches max(DIV,2) when leaving IDLE, at every wrap, and at every realign. DIV changes mid-period have no effect until then.
- Counter, each cycle when not IDLE:
  - If sync_edge or cnt==div_l-1: cnt<=0, TICK<=1.
  - Otherwise: cnt<=cnt+1, TICK<=0.
  - sync_edge coinciding with a natural wrap gives one TICK, not two.
- CLK_OUT <= (cnt_next < div_l>>1). For odd div_l the low phase is one cycle longer.
- In tolerance: sync_edge with cnt >= div_l-1-PHASE_TOL, or cnt <= PHASE_TOL. Anything else is out of tolerance.
- FSM states:
  - IDLE: ENABLE=0. cnt held 0; CLK_OUT, TICK and LOCKED are 0; sync ignored. ENABLE=1 -> ACQUIRE; the counter starts the next cycle with TICK=1.
  - ACQUIRE: every sync_edge realigns. The first in-tolerance sync_edge after at least one realign -> LOCKED with miss=0. Out-of-tolerance syncs realign silently, with no SYNC_ERR.
  - LOCKED, in-tolerance sync_edge: realign, miss<=0.
  - LOCKED, wrap with no sync_edge since the previous wrap: miss<=miss+1. miss reaching MISS_LIMIT -> ACQUIRE.
  - LOCKED, out-of-tolerance sync_edge: realign, SYNC_ERR=1 for one cycle, -> ACQUIRE.
  - Any state, ENABLE=0: -> IDLE next cycle, with outputs low the cycle after.
- LOCKED output is registered and equal to (state==LOCKED).
- cnt never exceeds div_l-1; no wrap-around overflow is possible for CNT_W.

Decomposition:
- Shared package sync_clk_pkg:
  - state encoding constants: IDLE=2'd0, ACQUIRE=2'd1, LOCKED=2'd2.
  - default CNT_W.
  - MIN_DIV=2.
- One sub-module: sync_edge_detect. It holds the SYNC_STAGES-deep synchronizer plus the rising-edge register, with ports CLK, RESET, D_ASYNC, EDGE.

Test Plan:
- Reset/enable: RESET=1 for 3 cycles, ENABLE=1, DIV=8, no sync -> TICK every 8 cycles; CLK_OUT high 4, low 4; LOCKED=0.
- Acquire and lock: DIV=8, PHASE_TOL=1, SYNC_IN pulses every 8 cycles starting arbitrarily -> first pulse realigns (TICK 3 cycles after sample), second sets LOCKED=1; no SYNC_ERR.
- Phase error: while LOCKED, sync arrives 3 cycles early (cnt=4) -> SYNC_ERR single pulse, LOCKED=0, cnt=0/TICK next cycle.
- Miss limit: LOCKED, MISS_LIMIT=4, syncs stopped -> LOCKED falls at the 4th wrap without sync; TICK continues every 8 cycles.
- Boundaries:
  - DIV=0 and DIV=1 -> period 2, CLK_OUT alternates.
  - DIV changed 8->5 mid-period -> current period stays 8, next is 5.
  - DIV=7 -> CLK_OUT high 3, low 4.
- Reset mid-operation: RESET pulsed while LOCKED at cnt=5 -> next cycle all outputs 0, state IDLE; requires re-acquire after re-enable.
